// File: rtl/frame_align.sv
// Frame aligner: finds SYNC_WORD at any of 32 bit offsets in a raw SERDES word
// stream, confirms it over LOCK_CNT frames, then emits word-aligned frames.
module frame_align #(
    parameter logic [31:0] SYNC_WORD  = 32'h1ACF_FC1D,
    parameter int          FRAME_LEN  = 16,
    parameter int          LOCK_CNT   = 3,
    parameter int          UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic        dout_sof,
    output logic        locked,
    output logic        align_err,
    output logic [4:0]  offset
);

    localparam int POS_W  = $clog2(FRAME_LEN);
    localparam int HIT_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t              state, state_next;
    logic [31:0]         prev;
    logic [POS_W-1:0]    pos, pos_inc;
    logic [HIT_W-1:0]    hit_cnt;
    logic [MISS_W-1:0]   miss_cnt;

    logic [63:0]         cat;
    logic [31:0]         match;
    logic                any_match;
    logic [4:0]          first_k;
    logic [31:0]         cand;
    logic                cand_hit;
    logic                at_sync;
    logic                hit_last;
    logic                miss_last;

    logic                out_take;
    logic                sof_take;
    logic                miss_take;

    // Older word sits in the low half, so offset 0 selects prev itself.
    assign cat = {din, prev};

    for (genvar k = 0; k < 32; k++) begin : g_cmp
        assign match[k] = (cat[k +: 32] == SYNC_WORD);
    end

    assign any_match = |match;

    always_comb begin
        first_k = '0;
        for (int k = 31; k >= 0; k--) begin
            if (match[k]) first_k = 5'(k);
        end
    end

    assign cand      = cat[offset +: 32];
    assign cand_hit  = (cand == SYNC_WORD);
    assign at_sync   = (pos == '0);
    assign pos_inc   = (pos == POS_LAST) ? '0 : pos + 1'b1;
    assign hit_last  = (hit_cnt == HIT_LAST);
    assign miss_last = (miss_cnt == MISS_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= SEARCH;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (din_valid) begin
            case (state)
                SEARCH: begin
                    if (any_match) state_next = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                end
                VERIFY: begin
                    if (at_sync) begin
                        if (!cand_hit)     state_next = SEARCH;
                        else if (hit_last) state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (at_sync && !cand_hit && miss_last) state_next = SEARCH;
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_take  = din_valid && (state == LOCKED);
        sof_take  = out_take && at_sync;
        miss_take = sof_take && !cand_hit;
    end

    // Alignment bookkeeping; a gap cycle leaves all of it untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev     <= '0;
            offset   <= '0;
            pos      <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (din_valid) begin
            prev <= din;
            case (state)
                SEARCH: begin
                    if (any_match) begin
                        offset   <= first_k;
                        pos      <= POS_W'(1);
                        hit_cnt  <= HIT_W'(1);
                        miss_cnt <= '0;
                    end
                end
                VERIFY: begin
                    pos <= pos_inc;
                    if (at_sync) begin
                        if (cand_hit) begin
                            hit_cnt <= hit_cnt + 1'b1;
                            if (hit_last) miss_cnt <= '0;
                        end else begin
                            hit_cnt <= '0;
                            pos     <= '0;
                        end
                    end
                end
                LOCKED: begin
                    pos <= pos_inc;
                    if (at_sync) begin
                        if (cand_hit) begin
                            miss_cnt <= '0;
                        end else if (miss_last) begin
                            miss_cnt <= '0;
                            hit_cnt  <= '0;
                            pos      <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output stage: one clock behind the accepted word; dout holds across gaps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            align_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            dout_valid <= out_take;
            dout_sof   <= sof_take;
            align_err  <= miss_take;
            locked     <= (state_next == LOCKED);
            if (out_take) dout <= cand;
        end
    end

endmodule

// File: tb/tb_frame_align.sv
// Directed bench for frame_align: aligned and 13-bit-shifted streams, lock loss,
// marginal misses, failed verify, and reset while locked with gaps.
module tb_frame_align;

    localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_sof;
    logic        locked;
    logic        align_err;
    logic [4:0]  offset;

    int total = 0;
    int bad = 0;
    int sh_cur = 0;
    logic bad_frame [0:15];

    frame_align dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .locked     (locked),
        .align_err  (align_err),
        .offset     (offset)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Original (aligned) stream: 16-word frames, sync in slot 0.
    function automatic logic [31:0] gen(input int m);
        if (m < 0) return 32'h0;
        if (m % 16 == 0) return bad_frame[m / 16] ? (SYNC ^ 32'h0001_0000) : SYNC;
        return 32'h5500_0000 | 32'(m);
    endfunction

    // Serial stream delayed by sh bits, then re-cut into 32-bit words.
    function automatic logic [31:0] shifted(input int m, input int sh);
        logic [63:0] t;
        t = {gen(m), gen(m - 1)};
        if (sh == 0) return gen(m);
        return t[(32 - sh) +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] d, input logic v);
        @(negedge clk);
        din = d;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int m);
        step(shifted(m, sh_cur), 1'b1);
    endtask

    task automatic gap();
        step($urandom, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        din_valid = 1'b0;
        for (int i = 0; i < 16; i++) bad_frame[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    int errs;
    int drops;
    int seen_lock;
    int seen_dv;

    initial begin
        for (int i = 0; i < 16; i++) bad_frame[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",   dout,              32'd0);
        chk("rst_dv",     32'(dout_valid),   32'd0);
        chk("rst_sof",    32'(dout_sof),     32'd0);
        chk("rst_locked", 32'(locked),       32'd0);
        chk("rst_err",    32'(align_err),    32'd0);
        chk("rst_offset", 32'(offset),       32'd0);

        // A: aligned stream
        do_reset();
        sh_cur = 0;
        for (int m = 0; m <= 50; m++) begin
            send(m);
            if (m == 1)  chk("A_offset", 32'(offset), 32'd0);
            if (m == 32) chk("A_lock_pre", 32'(locked), 32'd0);
            if (m == 33) begin
                chk("A_lock", 32'(locked), 32'd1);
                chk("A_dv_pre", 32'(dout_valid), 32'd0);
            end
            if (m >= 34) begin
                chk("A_dv",   32'(dout_valid), 32'd1);
                chk("A_dout", dout, gen(m - 1));
                chk("A_sof",  32'(dout_sof), 32'((m - 1) % 16 == 0));
            end
        end

        // B: stream shifted by 13 bits
        do_reset();
        sh_cur = 13;
        for (int m = 0; m <= 50; m++) begin
            send(m);
            if (m == 1)  chk("B_offset", 32'(offset), 32'd13);
            if (m == 32) chk("B_lock_pre", 32'(locked), 32'd0);
            if (m == 33) chk("B_lock", 32'(locked), 32'd1);
            if (m >= 34) begin
                chk("B_dout", dout, gen(m - 1));
                chk("B_sof",  32'(dout_sof), 32'((m - 1) % 16 == 0));
            end
        end

        // C: four corrupted syncs drop lock, three good frames relock
        do_reset();
        sh_cur = 13;
        for (int i = 3; i <= 6; i++) bad_frame[i] = 1'b1;
        errs = 0;
        for (int m = 0; m <= 150; m++) begin
            send(m);
            if (align_err) errs++;
            if (m == 96) chk("C_lock_held", 32'(locked), 32'd1);
            if (m == 97) begin
                chk("C_unlock",     32'(locked),     32'd0);
                chk("C_unlock_err", 32'(align_err),  32'd1);
                chk("C_unlock_sof", 32'(dout_sof),   32'd1);
                chk("C_unlock_dv",  32'(dout_valid), 32'd1);
                chk("C_unlock_dout", dout, gen(96));
            end
            if (m == 98)  chk("C_search_dv", 32'(dout_valid), 32'd0);
            if (m == 144) chk("C_relock_pre", 32'(locked), 32'd0);
            if (m == 145) begin
                chk("C_relock", 32'(locked), 32'd1);
                chk("C_offset", 32'(offset), 32'd13);
            end
            if (m == 146) chk("C_dout", dout, gen(145));
        end
        chk("C_err_pulses", 32'(errs), 32'd4);

        // D: three misses then a good sync keep lock
        do_reset();
        sh_cur = 0;
        for (int i = 3; i <= 5; i++) bad_frame[i] = 1'b1;
        errs = 0;
        drops = 0;
        for (int m = 0; m <= 100; m++) begin
            send(m);
            if (align_err) errs++;
            if (m >= 33 && !locked) drops++;
            if (m == 81) chk("D_miss3", 32'(dut.miss_cnt), 32'd3);
            if (m == 97) chk("D_miss0", 32'(dut.miss_cnt), 32'd0);
        end
        chk("D_err_pulses", 32'(errs), 32'd3);
        chk("D_drops", 32'(drops), 32'd0);

        // E: second sync corrupted during verify
        do_reset();
        sh_cur = 0;
        bad_frame[1] = 1'b1;
        seen_lock = 0;
        seen_dv = 0;
        for (int m = 0; m <= 40; m++) begin
            send(m);
            if (locked) seen_lock++;
            if (dout_valid) seen_dv++;
            if (m == 16) chk("E_hit1", 32'(dut.hit_cnt), 32'd1);
            if (m == 17) chk("E_hit0", 32'(dut.hit_cnt), 32'd0);
        end
        chk("E_never_lock", 32'(seen_lock), 32'd0);
        chk("E_never_dv", 32'(seen_dv), 32'd0);

        // F: lock with gaps, reset while locked, relock with gaps
        do_reset();
        sh_cur = 13;
        for (int m = 0; m <= 45; m++) begin
            if (m % 7 == 3) begin
                gap();
                chk("F_gap_dv", 32'(dout_valid), 32'd0);
                if (m >= 2) chk("F_gap_pos", 32'(dut.pos), 32'((m - 1) % 16));
                if (m - 1 >= 34) chk("F_gap_hold", dout, gen(m - 2));
            end
            send(m);
        end
        chk("F_locked", 32'(locked), 32'd1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("F_rst_dout",   dout,            32'd0);
        chk("F_rst_dv",     32'(dout_valid), 32'd0);
        chk("F_rst_sof",    32'(dout_sof),   32'd0);
        chk("F_rst_locked", 32'(locked),     32'd0);
        chk("F_rst_err",    32'(align_err),  32'd0);
        chk("F_rst_offset", 32'(offset),     32'd0);
        chk("F_rst_pos",    32'(dut.pos),    32'd0);
        step(shifted(46, 13), 1'b1);
        step(32'hDEAD_BEEF, 1'b0);
        chk("F_rst_hold", 32'(locked), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int m = 46; m <= 100; m++) begin
            if (m % 5 == 0) begin
                gap();
                chk("F2_gap_dv", 32'(dout_valid), 32'd0);
                if (m - 1 >= 49) chk("F2_gap_pos", 32'(dut.pos), 32'((m - 1) % 16));
            end
            send(m);
            if (m == 49) chk("F2_offset", 32'(offset), 32'd13);
            if (m == 80) chk("F2_lock_pre", 32'(locked), 32'd0);
            if (m == 81) chk("F2_lock", 32'(locked), 32'd1);
            if (m == 82) begin
                chk("F2_dv",   32'(dout_valid), 32'd1);
                chk("F2_dout", dout, gen(81));
            end
            if (m == 97) begin
                chk("F2_sof",      32'(dout_sof), 32'd1);
                chk("F2_sof_dout", dout, SYNC);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
